// File: rtl/updown_counter_n_if.sv
// Control and status bundle for the parametrised up/down counter.
interface updown_counter_n_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned STEP_W = 4
);
    logic              enable;
    logic              clear;
    logic              load;
    logic [N-1:0]      load_val;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic              wrap;
    logic [N-1:0]      max;
    logic [N-1:0]      count;
    logic              at_max;
    logic              at_zero;
    logic              rollover;

    // Block that drives the controls and observes the count.
    modport master (
        output enable, clear, load, load_val, dir, step, wrap, max,
        input  count, at_max, at_zero, rollover
    );

    // The counter itself.
    modport slave (
        input  enable, clear, load, load_val, dir, step, wrap, max,
        output count, at_max, at_zero, rollover
    );
endinterface

// File: rtl/updown_counter_n.sv
// N-bit up/down counter: programmable step, sync clear/load,
// wrap or saturate against a runtime max, registered rollover pulse.
module updown_counter_n #(
    parameter int unsigned N      = 8,
    parameter int unsigned STEP_W = 4
) (
    input logic               clk,
    input logic               nrst,
    updown_counter_n_if.slave bus
);
    localparam int unsigned SUM_W = N + 1;

    logic [N-1:0]      count_q;
    logic [N-1:0]      count_nxt;
    logic              roll_q;
    logic              roll_nxt;
    logic [STEP_W-1:0] step_v;
    logic [SUM_W-1:0]  sum;
    logic [N-1:0]      step_n;

    assign step_v = bus.step;
    assign sum    = {1'b0, count_q} + SUM_W'(step_v);
    assign step_n = N'(step_v);

    // Next count and rollover, priority clear > load > enable > hold.
    always_comb begin
        count_nxt = count_q;
        roll_nxt  = 1'b0;
        if (bus.clear) begin
            count_nxt = '0;
        end else if (bus.load) begin
            count_nxt = (bus.load_val > bus.max) ? bus.max : bus.load_val;
        end else if (bus.enable && (step_v != '0)) begin
            if (bus.dir) begin
                // An out-of-range count also lands here, since sum > max.
                if (sum <= {1'b0, bus.max}) begin
                    count_nxt = sum[N-1:0];
                end else if (bus.wrap) begin
                    count_nxt = '0;
                    roll_nxt  = 1'b1;
                end else begin
                    count_nxt = bus.max;
                end
            end else begin
                if (count_q >= step_n) begin
                    count_nxt = count_q - step_n;
                end else if (bus.wrap) begin
                    count_nxt = bus.max;
                    roll_nxt  = 1'b1;
                end else begin
                    count_nxt = '0;
                end
            end
        end
    end

    // Count and rollover state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= '0;
            roll_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            roll_q  <= roll_nxt;
        end
    end

    // Outputs: registered count/rollover, zero-latency flags.
    assign bus.count    = count_q;
    assign bus.rollover = roll_q;
    assign bus.at_max   = (count_q == bus.max);
    assign bus.at_zero  = (count_q == '0);
endmodule

// File: tb/tb_updown_counter_n.sv
// Directed self-checking bench for updown_counter_n (N=8, STEP_W=4).
module tb_updown_counter_n;
    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    updown_counter_n_if #(.N(8), .STEP_W(4)) bus ();

    updown_counter_n #(.N(8), .STEP_W(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 8'd0;
        bus.dir      = 1'b1;
        bus.step     = 4'd1;
        bus.wrap     = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.max = 8'd0;
        nrst    = 1'b0;
        #3;
        checks++;
        if (bus.count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", bus.count);
        end
        checks++;
        if (bus.at_max !== 1'b1 || bus.at_zero !== 1'b1 || bus.rollover !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got at_max=%b at_zero=%b rollover=%b required 1 1 0",
                     bus.at_max, bus.at_zero, bus.rollover);
        end
        bus.max = 8'd5;
        #1;
        checks++;
        if (bus.at_max !== 1'b0) begin
            errors++;
            $display("FAIL reset_at_max_comb: got %b required 0", bus.at_max);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick();
        checks++;
        if (bus.count !== 8'd0) begin
            errors++;
            $display("FAIL reset_release_hold: got %0d required 0", bus.count);
        end
    endtask

    task automatic test_up_wrap();
        bus.max    = 8'd15;
        bus.step   = 4'd1;
        bus.wrap   = 1'b1;
        bus.dir    = 1'b1;
        bus.enable = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (bus.count !== 8'(i) || bus.rollover !== 1'b0) begin
                errors++;
                $display("FAIL up_wrap_step%0d: got count=%0d rollover=%b required %0d 0",
                         i, bus.count, bus.rollover, i);
            end
        end
        checks++;
        if (bus.at_max !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap_at_max: got %b required 1", bus.at_max);
        end
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.rollover !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap_edge: got count=%0d rollover=%b required 0 1",
                     bus.count, bus.rollover);
        end
        tick();
        checks++;
        if (bus.count !== 8'd1 || bus.rollover !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap_after: got count=%0d rollover=%b required 1 0",
                     bus.count, bus.rollover);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_up_saturate();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'd4;
        exp_seq[1] = 8'd8;
        exp_seq[2] = 8'd10;
        exp_seq[3] = 8'd10;
        bus.clear = 1'b1;
        tick();
        bus.clear  = 1'b0;
        bus.max    = 8'd10;
        bus.step   = 4'd4;
        bus.wrap   = 1'b0;
        bus.dir    = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.count !== exp_seq[i] || bus.rollover !== 1'b0) begin
                errors++;
                $display("FAIL up_sat_%0d: got count=%0d rollover=%b required %0d 0",
                         i, bus.count, bus.rollover, exp_seq[i]);
            end
        end
        bus.wrap = 1'b1;
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.rollover !== 1'b1) begin
            errors++;
            $display("FAIL up_sat_then_wrap: got count=%0d rollover=%b required 0 1",
                     bus.count, bus.rollover);
        end
        bus.enable = 1'b0;
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.rollover !== 1'b0) begin
            errors++;
            $display("FAIL up_sat_pulse_end: got count=%0d rollover=%b required 0 0",
                     bus.count, bus.rollover);
        end
    endtask

    task automatic test_down();
        bus.max      = 8'd20;
        bus.load_val = 8'd3;
        bus.load     = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.count !== 8'd3) begin
            errors++;
            $display("FAIL down_load: got %0d required 3", bus.count);
        end
        bus.dir    = 1'b0;
        bus.step   = 4'd2;
        bus.wrap   = 1'b1;
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.count !== 8'd1 || bus.rollover !== 1'b0) begin
            errors++;
            $display("FAIL down_sub: got count=%0d rollover=%b required 1 0",
                     bus.count, bus.rollover);
        end
        tick();
        checks++;
        if (bus.count !== 8'd20 || bus.rollover !== 1'b1 || bus.at_max !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: got count=%0d rollover=%b at_max=%b required 20 1 1",
                     bus.count, bus.rollover, bus.at_max);
        end
        bus.enable   = 1'b0;
        bus.load_val = 8'd1;
        bus.load     = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.wrap   = 1'b0;
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.rollover !== 1'b0 || bus.at_zero !== 1'b1) begin
            errors++;
            $display("FAIL down_sat: got count=%0d rollover=%b at_zero=%b required 0 0 1",
                     bus.count, bus.rollover, bus.at_zero);
        end
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.rollover !== 1'b0) begin
            errors++;
            $display("FAIL down_sat_hold: got count=%0d rollover=%b required 0 0",
                     bus.count, bus.rollover);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_priority();
        bus.max      = 8'd50;
        bus.load_val = 8'd7;
        bus.load     = 1'b1;
        tick();
        bus.clear  = 1'b1;
        bus.enable = 1'b1;
        bus.dir    = 1'b1;
        bus.step   = 4'd1;
        tick();
        checks++;
        if (bus.count !== 8'd0) begin
            errors++;
            $display("FAIL prio_clear: got %0d required 0", bus.count);
        end
        bus.clear    = 1'b0;
        bus.load_val = 8'd200;
        tick();
        checks++;
        if (bus.count !== 8'd50 || bus.at_max !== 1'b1) begin
            errors++;
            $display("FAIL prio_load_clamp: got count=%0d at_max=%b required 50 1",
                     bus.count, bus.at_max);
        end
        bus.load = 1'b0;
        bus.step = 4'd0;
        tick();
        checks++;
        if (bus.count !== 8'd50) begin
            errors++;
            $display("FAIL step_zero_hold: got %0d required 50", bus.count);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_out_of_range();
        // count=50, lower max below it
        bus.max    = 8'd30;
        bus.dir    = 1'b1;
        bus.step   = 4'd1;
        bus.wrap   = 1'b0;
        tick();
        checks++;
        if (bus.count !== 8'd50) begin
            errors++;
            $display("FAIL oor_hold: got %0d required 50", bus.count);
        end
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.count !== 8'd30 || bus.rollover !== 1'b0) begin
            errors++;
            $display("FAIL oor_up_sat: got count=%0d rollover=%b required 30 0",
                     bus.count, bus.rollover);
        end
        bus.max  = 8'd20;
        bus.wrap = 1'b1;
        tick();
        checks++;
        if (bus.count !== 8'd0 || bus.rollover !== 1'b1) begin
            errors++;
            $display("FAIL oor_up_wrap: got count=%0d rollover=%b required 0 1",
                     bus.count, bus.rollover);
        end
        bus.enable   = 1'b0;
        bus.max      = 8'd60;
        bus.load_val = 8'd50;
        bus.load     = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.max    = 8'd20;
        bus.dir    = 1'b0;
        bus.step   = 4'd4;
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.count !== 8'd46 || bus.rollover !== 1'b0 || bus.at_max !== 1'b0) begin
            errors++;
            $display("FAIL oor_down_sub: got count=%0d rollover=%b at_max=%b required 46 0 0",
                     bus.count, bus.rollover, bus.at_max);
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.max      = 8'd9;
        bus.load_val = 8'd0;
        bus.load     = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.dir    = 1'b0;
        bus.step   = 4'd1;
        bus.wrap   = 1'b1;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        checks++;
        if (bus.count !== 8'd9 || bus.rollover !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: got count=%0d rollover=%b required 9 1",
                     bus.count, bus.rollover);
        end
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if (bus.count !== 8'd0 || bus.rollover !== 1'b0 || bus.at_zero !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got count=%0d rollover=%b at_zero=%b required 0 0 1",
                     bus.count, bus.rollover, bus.at_zero);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_up_wrap();
        test_up_saturate();
        test_down();
        test_priority();
        test_out_of_range();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
